// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the sequential multiply/divide unit: ALU op codes,
// FSM state encoding and op-classification helpers.
package muldiv_seq_pkg;

  localparam logic [4:0] ALU_MUL    = 5'h08;
  localparam logic [4:0] ALU_MULH   = 5'h09;
  localparam logic [4:0] ALU_MULHSU = 5'h0A;
  localparam logic [4:0] ALU_MULHU  = 5'h0B;
  localparam logic [4:0] ALU_DIV    = 5'h0C;
  localparam logic [4:0] ALU_DIVU   = 5'h0D;
  localparam logic [4:0] ALU_REM    = 5'h0E;
  localparam logic [4:0] ALU_REMU   = 5'h0F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic op_known(input logic [4:0] op);
    return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction

  function automatic logic op_is_div(input logic [4:0] op);
    return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction

  function automatic logic op_is_rem(input logic [4:0] op);
    return op inside {ALU_REM, ALU_REMU};
  endfunction

  function automatic logic op_is_hi(input logic [4:0] op);
    return op inside {ALU_MULH, ALU_MULHSU, ALU_MULHU};
  endfunction

  function automatic logic op_a_signed(input logic [4:0] op);
    return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
  endfunction

  function automatic logic op_b_signed(input logic [4:0] op);
    return op inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM};
  endfunction

endpackage

// File: rtl/muldiv_seq_step.sv
// One combinational iteration: shift-add for multiply, restoring subtract
// for divide (acc holds {remainder, dividend/quotient} when dividing).
module muldiv_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc_in,
  input  logic [2*XLEN-1:0] mcand_in,
  input  logic [XLEN-1:0]   opb_in,
  output logic [2*XLEN-1:0] acc_out,
  output logic [2*XLEN-1:0] mcand_out,
  output logic [XLEN-1:0]   opb_out
);

  logic [XLEN:0] rem_shift;
  logic [XLEN:0] diff;

  always_comb begin
    rem_shift = {acc_in[2*XLEN-1:XLEN], acc_in[XLEN-1]};
    diff      = rem_shift - {1'b0, opb_in};
    mcand_out = mcand_in;
    opb_out   = opb_in;
    if (is_div) begin
      // Borrow out of the top bit means the divisor did not fit: restore.
      if (diff[XLEN]) acc_out = {rem_shift[XLEN-1:0], acc_in[XLEN-2:0], 1'b0};
      else            acc_out = {diff[XLEN-1:0], acc_in[XLEN-2:0], 1'b1};
    end else begin
      acc_out   = acc_in + (opb_in[0] ? mcand_in : '0);
      mcand_out = mcand_in << 1;
      opb_out   = opb_in >> 1;
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV-style multiply/divide unit: one step per cycle, sign fix-up
// on completion, valid/ready handshake on both sides.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      alu_op,
  input  logic            s_32,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam bit IS64 = (XLEN == 64);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  function automatic logic [XLEN-1:0] fit(input logic w, input logic [XLEN-1:0] v);
    return w ? sext32(v[31:0]) : v;
  endfunction

  state_t            state;
  logic [4:0]        op_q;
  logic              w_q, neg_q;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc, mcand;
  logic [XLEN-1:0]   opb;

  logic              w_in, sign_a, sign_b, div_zero, div_ovf;
  logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag;
  logic [2*XLEN-1:0] acc_nx, mcand_nx, prod;
  logic [XLEN-1:0]   opb_nx, quo, rem, mul_sel, res_fin;

  always_comb begin
    w_in   = IS64 && s_32;
    a_ext  = w_in ? (op_a_signed(alu_op) ? sext32(op_a[31:0]) : XLEN'(op_a[31:0])) : op_a;
    b_ext  = w_in ? (op_b_signed(alu_op) ? sext32(op_b[31:0]) : XLEN'(op_b[31:0])) : op_b;
    sign_a = op_a_signed(alu_op) && a_ext[XLEN-1];
    sign_b = op_b_signed(alu_op) && b_ext[XLEN-1];
    a_mag  = sign_a ? -a_ext : a_ext;
    b_mag  = sign_b ? -b_ext : b_ext;
    div_zero = op_is_div(alu_op) && (b_ext == '0);
    div_ovf  = op_is_div(alu_op) && op_b_signed(alu_op) && (b_ext == '1) &&
               (a_ext == (w_in ? sext32(32'h8000_0000) : MOST_NEG));
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div    (op_is_div(op_q)),
    .acc_in    (acc),
    .mcand_in  (mcand),
    .opb_in    (opb),
    .acc_out   (acc_nx),
    .mcand_out (mcand_nx),
    .opb_out   (opb_nx)
  );

  always_comb begin
    prod    = neg_q ? -acc_nx : acc_nx;
    quo     = neg_q ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
    rem     = neg_q ? -acc_nx[2*XLEN-1:XLEN] : acc_nx[2*XLEN-1:XLEN];
    mul_sel = op_is_hi(op_q) ? (w_q ? XLEN'(prod[63:32]) : prod[2*XLEN-1:XLEN])
                             : prod[XLEN-1:0];
    if (op_is_div(op_q)) res_fin = fit(w_q, op_is_rem(op_q) ? rem : quo);
    else                 res_fin = fit(w_q, mul_sel);
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      op_q   <= '0;
      w_q    <= 1'b0;
      neg_q  <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      opb    <= '0;
      result <= '0;
    end else if (kill) begin
      state  <= ST_IDLE;
      result <= '0;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          op_q  <= alu_op;
          w_q   <= w_in;
          neg_q <= op_is_rem(alu_op) ? sign_a : (sign_a ^ sign_b);
          cnt   <= w_in ? CW'(31) : CW'(XLEN - 1);
          opb   <= b_mag;
          if (!op_known(alu_op)) begin
            state  <= ST_DONE;
            result <= '0;
          end else if (div_zero) begin
            state  <= ST_DONE;
            result <= op_is_rem(alu_op) ? fit(w_in, op_a) : '1;
          end else if (div_ovf) begin
            state  <= ST_DONE;
            result <= op_is_rem(alu_op) ? '0 : fit(w_in, op_a);
          end else begin
            state <= ST_BUSY;
            // Word divides pre-align the dividend so its MSB is shifted out first.
            if (op_is_div(alu_op)) begin
              acc   <= {{XLEN{1'b0}}, (w_in ? (a_mag << (XLEN - 32)) : a_mag)};
              mcand <= '0;
            end else begin
              acc   <= '0;
              mcand <= {{XLEN{1'b0}}, a_mag};
            end
          end
        end
        ST_BUSY: begin
          acc   <= acc_nx;
          mcand <= mcand_nx;
          opb   <= opb_nx;
          cnt   <= cnt - 1'b1;
          if (cnt == '0) begin
            state  <= ST_DONE;
            result <= res_fin;
          end
        end
        ST_DONE: if (out_ready) begin
          state  <= ST_IDLE;
          result <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq at XLEN=32 and XLEN=64 with a result scoreboard.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid32 = 1'b0, in_valid64 = 1'b0;
  logic [4:0]  alu_op = '0;
  logic        s_32 = 1'b0;
  logic [63:0] op_a = '0, op_b = '0;
  logic        kill = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready32, in_ready64, out_valid32, out_valid64;
  logic [31:0] result32;
  logic [63:0] result64;

  logic        sel_wide = 1'b0;
  logic        ov_sel, ir_sel;
  logic [63:0] res_sel;

  typedef struct {
    string       tag;
    logic [63:0] value;
    int unsigned lat;
  } exp_t;

  exp_t        sb[$];
  int unsigned checks = 0;
  int unsigned failures = 0;

  always #5 clock = ~clock;

  muldiv_seq #(.XLEN(32)) dut32 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid32), .in_ready(in_ready32),
    .alu_op(alu_op), .s_32(s_32), .op_a(op_a[31:0]), .op_b(op_b[31:0]), .kill(kill),
    .out_valid(out_valid32), .out_ready(out_ready), .result(result32)
  );

  muldiv_seq #(.XLEN(64)) dut64 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid64), .in_ready(in_ready64),
    .alu_op(alu_op), .s_32(s_32), .op_a(op_a), .op_b(op_b), .kill(kill),
    .out_valid(out_valid64), .out_ready(out_ready), .result(result64)
  );

  assign ov_sel  = sel_wide ? out_valid64 : out_valid32;
  assign ir_sel  = sel_wide ? in_ready64 : in_ready32;
  assign res_sel = sel_wide ? result64 : {32'h0, result32};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op, wait (bounded) for out_valid, optionally stall, then drain.
  task automatic run(input bit wide, input logic [4:0] op, input logic s32,
                     input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] exp, input int unsigned lat,
                     input int unsigned stall, input string tag);
    exp_t        e;
    int unsigned n;
    logic        stable;
    @(negedge clock);
    sel_wide = wide;
    alu_op = op; s_32 = s32; op_a = a; op_b = b;
    if (wide) in_valid64 = 1'b1; else in_valid32 = 1'b1;
    sb.push_back('{tag, exp, lat});
    chk({tag, "_in_ready"}, 64'(ir_sel), 64'd1);
    @(posedge clock); #1;
    in_valid32 = 1'b0; in_valid64 = 1'b0;
    n = 1;
    while (n < 200) begin
      @(negedge clock);
      if (ov_sel) break;
      @(posedge clock);
      n++;
    end
    e = sb.pop_front();
    chk({e.tag, "_valid"}, 64'(ov_sel), 64'd1);
    chk({e.tag, "_result"}, res_sel, e.value);
    chk({e.tag, "_latency"}, 64'(n), 64'(e.lat));
    stable = 1'b1;
    for (int unsigned i = 0; i < stall; i++) begin
      @(posedge clock); @(negedge clock);
      if (ov_sel !== 1'b1 || res_sel !== e.value) stable = 1'b0;
    end
    if (stall > 0) chk({e.tag, "_stall_stable"}, 64'(stable), 64'd1);
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    @(negedge clock);
    chk({e.tag, "_back_idle"}, {62'h0, ir_sel, ov_sel}, 64'd2);
  endtask

  initial begin
    logic seen;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset_in_ready", 64'(in_ready32), 64'd1);
    chk("reset_out_valid", 64'(out_valid32), 64'd0);
    chk("reset_result", 64'(result32), 64'd0);
    reset_n = 1'b1;

    run(0, ALU_MUL,    0, 64'd7,          64'd6,          64'd42,           33, 0, "mul_7x6");
    run(0, ALU_MUL,    0, 64'hFFFF_FFFD,  64'd5,          64'hFFFF_FFF1,    33, 0, "mul_neg");
    run(0, ALU_MULH,   0, 64'h8000_0000,  64'h8000_0000,  64'h4000_0000,    33, 0, "mulh");
    run(0, ALU_MULHSU, 0, 64'hFFFF_FFFF,  64'hFFFF_FFFF,  64'hFFFF_FFFF,    33, 0, "mulhsu");
    run(0, ALU_MULHU,  0, 64'hFFFF_FFFF,  64'hFFFF_FFFF,  64'hFFFF_FFFE,    33, 0, "mulhu");
    run(0, ALU_DIV,    0, 64'hFFFF_FFF9,  64'd2,          64'hFFFF_FFFD,    33, 0, "div_m7_2");
    run(0, ALU_REM,    0, 64'hFFFF_FFF9,  64'd2,          64'hFFFF_FFFF,    33, 0, "rem_m7_2");
    run(0, ALU_DIVU,   0, 64'd100,        64'd7,          64'd14,           33, 0, "divu");
    run(0, ALU_REMU,   0, 64'd100,        64'd7,          64'd2,            33, 0, "remu");
    run(0, ALU_DIVU,   0, 64'hFFFF_FFFF,  64'd1,          64'hFFFF_FFFF,    33, 0, "divu_max");
    run(0, ALU_DIV,    0, 64'd7,          64'd0,          64'hFFFF_FFFF,    1,  0, "div_by0");
    run(0, ALU_REM,    0, 64'd7,          64'd0,          64'd7,            1,  0, "rem_by0");
    run(0, ALU_DIV,    0, 64'h8000_0000,  64'hFFFF_FFFF,  64'h8000_0000,    1,  0, "div_ovf");
    run(0, ALU_REM,    0, 64'h8000_0000,  64'hFFFF_FFFF,  64'd0,            1,  0, "rem_ovf");
    run(0, 5'h1F,      0, 64'd9,          64'd3,          64'd0,            1,  0, "bad_op");
    run(0, ALU_MUL,    0, 64'd7,          64'd6,          64'd42,           33, 5, "mul_stall");

    // kill during the 10th BUSY cycle
    @(negedge clock);
    sel_wide = 1'b0; alu_op = ALU_MUL; s_32 = 1'b0; op_a = 64'd7; op_b = 64'd6;
    in_valid32 = 1'b1;
    @(posedge clock); #1;
    in_valid32 = 1'b0;
    repeat (9) @(posedge clock);
    @(negedge clock);
    kill = 1'b1;
    @(posedge clock); #1;
    kill = 1'b0;
    @(negedge clock);
    chk("kill_idle", {62'h0, in_ready32, out_valid32}, 64'd2);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (out_valid32) seen = 1'b1;
    end
    chk("kill_no_valid", 64'(seen), 64'd0);

    // asynchronous reset in the middle of a divide
    @(negedge clock);
    alu_op = ALU_DIVU; op_a = 64'd100; op_b = 64'd7; in_valid32 = 1'b1;
    @(posedge clock); #1;
    in_valid32 = 1'b0;
    repeat (5) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_state", {62'h0, in_ready32, out_valid32}, 64'd2);
    chk("async_rst_result", 64'(result32), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (40) @(negedge clock);
    chk("post_rst_idle", {62'h0, in_ready32, out_valid32}, 64'd2);

    run(1, ALU_DIV,   1, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
        64'hFFFF_FFFF_8000_0000, 1, 0, "divw_ovf");
    run(1, ALU_MUL,   1, 64'h1_0000, 64'h1_0000, 64'd0, 33, 0, "mulw");
    run(1, ALU_DIV,   1, 64'h0000_0000_FFFF_FFF9, 64'd2,
        64'hFFFF_FFFF_FFFF_FFFD, 33, 0, "divw_m7_2");
    run(1, ALU_MULHU, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 65, 0, "mulhu64");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
